// File: rtl/serial_mag_compare.sv
// serial_mag_compare
//   Bit-serial magnitude comparator back end. It consumes one h/e/l decision
//   per accepted bit, with the operands fed MSB-first. After WIDTH bits it
//   reports a registered greater/equal/less verdict together with a
//   one-cycle done pulse.
//
//   Optional feature macro: SERCMP_ONEHOT_CHK_EN
//     When defined, an accepted bit whose {h,e,l} is not one-hot sets the
//     sticky err flag. When undefined, err is tied to 0.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a comparison (accepted in IDLE or DONE only)
//   bit_valid  h/e/l carry a bit decision this cycle (counted in SHIFT only)
//   h, e, l    upstream 1-bit verdict: a>b, a==b, a<b
//   busy       high while in SHIFT
//   done       one-cycle pulse when gt/eq/lt are updated
//   gt, eq, lt registered one-hot verdict, held until the next done
//   err        sticky non-one-hot input flag
module serial_mag_compare #(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic h,
    input  logic e,
    input  logic l,
    output logic busy,
    output logic done,
    output logic gt,
    output logic eq,
    output logic lt,
    output logic err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        D_EQ,
        D_GT,
        D_LT
    } dec_t;

    state_t        state_q;
    dec_t          dec_q;
    dec_t          dec_d;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          gt_q;
    logic          eq_q;
    logic          lt_q;

    logic start_acc;
    logic bit_acc;
    logic last_bit;

    assign start_acc = start && (state_q != S_SHIFT);
    assign bit_acc   = bit_valid && (state_q == S_SHIFT);
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));

    // The first non-equal bit (MSB-first) decides the verdict. Priority is
    // h > l > e, and an all-zero triple behaves like e.
    always_comb begin
        dec_d = dec_q;
        if (dec_q == D_EQ) begin
            if (h) begin
                dec_d = D_GT;
            end else if (l) begin
                dec_d = D_LT;
            end else if (e) begin
                dec_d = D_EQ;
            end else begin
                dec_d = D_EQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dec_q   <= D_EQ;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_acc) begin
                        state_q <= S_SHIFT;
                        dec_q   <= D_EQ;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (bit_acc) begin
                        cnt_q <= cnt_q + CW'(1);
                        dec_q <= dec_d;
                        // Results load from the decision that already
                        // includes the final bit.
                        if (last_bit) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            gt_q    <= (dec_d == D_GT);
                            eq_q    <= (dec_d == D_EQ);
                            lt_q    <= (dec_d == D_LT);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;

`ifdef SERCMP_ONEHOT_CHK_EN
    logic err_q;
    logic hel_onehot;

    assign hel_onehot = (h & ~e & ~l) | (~h & e & ~l) | (~h & ~e & l);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (start_acc) begin
            err_q <= 1'b0;
        end else if (bit_acc && !hel_onehot) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_mag_compare.sv
module tb_serial_mag_compare;

    localparam int unsigned WIDTH = 4;
`ifdef SERCMP_ONEHOT_CHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    localparam logic [2:0] B_H = 3'b100;
    localparam logic [2:0] B_E = 3'b010;
    localparam logic [2:0] B_L = 3'b001;
    localparam logic [2:0] B_Z = 3'b000;

    logic clk = 1'b0;
    logic rst_n, start, bit_valid, h, e, l;
    logic busy, done, gt, eq, lt, err;

    serial_mag_compare #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .h         (h),
        .e         (e),
        .l         (l),
        .busy      (busy),
        .done      (done),
        .gt        (gt),
        .eq        (eq),
        .lt        (lt),
        .err       (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        gt;
        logic        eq;
        logic        lt;
        logic        err;
        int unsigned due;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    int   checks   = 0;
    int   failures = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mx = sb.pop_front();
                check("gt", {31'd0, gt}, {31'd0, mx.gt});
                check("eq", {31'd0, eq}, {31'd0, mx.eq});
                check("lt", {31'd0, lt}, {31'd0, mx.lt});
                check("err_at_done", {31'd0, err}, {31'd0, mx.err});
                check("busy_at_done", {31'd0, busy}, 32'd0);
                check("done_cycle", cyc, mx.due);
            end
        end
        prev_done = done;
    end

    task automatic drive(input logic s, input logic bv, input logic [2:0] hel);
        @(negedge clk);
        start     = s;
        bit_valid = bv;
        {h, e, l} = hel;
    endtask

    // Called right after the drive() that raises start; latency counts edges
    // from the start-sampling edge to the edge raising done.
    task automatic expect_res(input logic g, input logic q, input logic t,
                              input logic er, input int unsigned lat);
        exp_t x;
        x.gt  = g;
        x.eq  = q;
        x.lt  = t;
        x.err = er;
        x.due = cyc + 1 + lat;
        sb.push_back(x);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_gt"},   {31'd0, gt},   32'd0);
        check({tag, "_eq"},   {31'd0, eq},   32'd0);
        check({tag, "_lt"},   {31'd0, lt},   32'd0);
        check({tag, "_err"},  {31'd0, err},  32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bit_valid = 1'b0;
        {h, e, l} = B_Z;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, B_Z);
        drive(0, 1, B_H);   // bit_valid outside SHIFT must be ignored
        drive(0, 0, B_Z);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);

        // A=1010 B=1001: e e h l -> gt, trailing l ignored
        drive(1, 0, B_Z);
        expect_res(1, 0, 0, 1'b0, 4);
        drive(0, 1, B_E);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        drive(0, 1, B_E);
        drive(0, 1, B_H);
        drive(0, 1, B_L);
        drive(0, 0, B_Z);
        drive(0, 0, B_Z);
        check("idle_after_done_busy", {31'd0, busy}, 32'd0);
        check("gt_held", {31'd0, gt}, 32'd1);

        // A=0110 B=0110 with a 2-cycle gap -> eq, latency 6
        drive(1, 0, B_Z);
        expect_res(0, 1, 0, 1'b0, 6);
        drive(0, 1, B_E);
        drive(0, 1, B_E);
        drive(0, 0, B_H);
        drive(0, 0, B_L);
        drive(0, 1, B_E);
        drive(0, 1, B_E);
        drive(0, 0, B_Z);
        drive(0, 0, B_Z);

        // start mid-SHIFT ignored; start in DONE cycle -> A=0001 B=0010 lt
        drive(1, 0, B_Z);
        expect_res(1, 0, 0, 1'b0, 4);
        drive(0, 1, B_E);
        drive(1, 1, B_H);
        drive(0, 1, B_E);
        drive(0, 1, B_E);
        drive(1, 0, B_Z);   // this cycle is DONE
        expect_res(0, 0, 1, 1'b0, 4);
        drive(0, 1, B_E);
        check("busy_back_to_back", {31'd0, busy}, 32'd1);
        drive(0, 1, B_E);
        drive(0, 1, B_L);
        drive(0, 1, B_H);
        drive(0, 0, B_Z);
        drive(0, 0, B_Z);

        // Reset mid-operation after 2 bits
        drive(1, 0, B_Z);
        drive(0, 1, B_E);
        drive(0, 1, B_E);
        @(negedge clk);
        bit_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, B_Z);
        expect_res(1, 0, 0, 1'b0, 4);
        drive(0, 1, B_H);
        drive(0, 1, B_L);
        drive(0, 1, B_E);
        drive(0, 1, B_E);
        drive(0, 0, B_Z);
        drive(0, 0, B_Z);

        // Non-one-hot bit h=l=1 -> gt; err only with the check enabled
        drive(1, 0, B_Z);
        expect_res(1, 0, 0, CHK, 4);
        drive(0, 1, 3'b101);
        drive(0, 1, B_E);
        check("err_after_bad_bit", {31'd0, err}, {31'd0, CHK});
        drive(0, 1, B_E);
        drive(0, 1, B_E);
        drive(0, 0, B_Z);
        drive(0, 0, B_Z);
        drive(0, 0, B_Z);
        check("err_sticky", {31'd0, err}, {31'd0, CHK});
        drive(1, 0, B_Z);
        expect_res(0, 1, 0, 1'b0, 4);
        drive(0, 1, B_E);
        check("err_cleared_by_start", {31'd0, err}, 32'd0);
        drive(0, 1, B_E);
        drive(0, 1, B_E);
        drive(0, 1, B_E);
        drive(0, 0, B_Z);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) check("scoreboard_drain", sb.size(), 32'd0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
